vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set system clocks per pixel (100 MHz -> 25 MHz).
REQ-002 Parameters H_VISIBLE 640, H_FP 16, H_SYNC 96, H_BP 48 SHALL set horizontal timing in pixels.
REQ-003 Parameters V_VISIBLE 480, V_FP 10, V_SYNC 2, V_BP 33 SHALL set vertical timing in lines.
REQ-004 clk  input  1  system clock; the block SHALL use this single clock for all logic.
REQ-005 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-006 pixel_color  input  12  {R[3:0],G[3:0],B[3:0]} from the grid renderer for the current curr_pix_x/curr_pix_y.
REQ-007 curr_pix_x  output  10  horizontal counter, 0..799.
REQ-008 curr_pix_y  output  10  vertical counter, 0..524.
REQ-009 video_on  output  1  high while curr_pix_x<640 and curr_pix_y<480, decoded combinationally from the counters.
REQ-010 pixel_tick  output  1  one-clk strobe, once every CLK_DIV clks.
REQ-011 frame_start  output  1  one-clk pulse marking counter wrap to (0,0).
REQ-012 hsync, vsync  output  1 each  active-low sync, registered.
REQ-013 vga_red, vga_green, vga_blue  output  4 each  registered, blanked pixel color.

Function
REQ-014 A 2-bit divider SHALL increment every clk, wrapping from CLK_DIV-1 to 0; pixel_tick SHALL be high exactly when the divider equals CLK_DIV-1.
REQ-015 curr_pix_x SHALL advance only on clks with pixel_tick=1; at 799 it SHALL wrap to 0.
REQ-016 curr_pix_y SHALL advance only on clks where pixel_tick=1 and curr_pix_x=799; at 524 it SHALL wrap to 0.
REQ-017 Counters SHALL hold stable for CLK_DIV clks per pixel, so the combinational renderer has CLK_DIV-1 clks of settle margin.
REQ-018 hsync SHALL be registered every clk as low iff curr_pix_x is in 656..751, giving exactly 1 clk lag behind the counters.
REQ-019 vsync SHALL be registered every clk as low iff curr_pix_y is in 490..491, with 1 clk lag.
REQ-020 vga_red/green/blue SHALL be registered every clk as pixel_color fields when video_on=1, else 4'h0, with 1 clk lag, aligned with hsync/vsync.
REQ-021 frame_start SHALL be high for exactly the one clk following the edge on which the counters wrap from (799,524) to (0,0); no pulse SHALL occur on the first frame after reset.
REQ-022 Total frame length SHALL be 800x525 pixels = 420000 pixel_ticks = 1680000 clks at CLK_DIV=4.
REQ-023 pixel_color values outside the visible window SHALL never reach the outputs.
REQ-024 All counter comparisons SHALL be unsigned 10-bit; no counter value above 799 (h) or 524 (v) SHALL ever occur.

Reset
REQ-025 With rst=1 at a clk edge: divider=0, curr_pix_x=0, curr_pix_y=0, hsync=1, vsync=1, vga_red/green/blue=0, frame_start=0.
REQ-026 While rst=1, pixel_tick SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL take effect on the next edge and override any pending tick, wrap, or frame_start.
REQ-028 After rst falls, the first pixel_tick SHALL occur on the 4th clk (divider=3), and curr_pix_x SHALL become 1 on the following edge.

Verification
REQ-029 Reset release -> pixel_tick pattern 0,0,0,1 repeating; x=1 after 4 clks; x=0,y=1 after 3200 clks.
REQ-030 Free-run one line -> hsync low for exactly 384 consecutive clks, starting 1 clk after x first reads 656; video_on low for x 640..799.
REQ-031 Free-run one frame -> vsync low for exactly 6400 clks, starting 1 clk after y reaches 490; frame_start pulses once per 1680000 clks, each pulse 1 clk wide.
REQ-032 pixel_color held at 12'hF00 -> vga_red=4'hF, green=0, blue=0 while video_on is high (1-clk lag); all RGB=0 from 1 clk after x=640 and for all lines with y>=480.
REQ-033 pixel_color stepped 12'h0F0 -> 12'h00F mid-pixel -> RGB tracks the new value on the next clk; hsync/vsync are unaffected.
REQ-034 rst pulsed for 1 clk at x=300, y=200 -> next clk shows x=0, y=0, syncs high, RGB=0, no frame_start; normal timing resumes per REQ-028.

Source files
------------

// File: rtl/vga_if.sv
// Bundle of the VGA generator's renderer handshake and monitor-facing outputs.
// The generator drives timing and color; the renderer supplies pixel_color.
interface vga_if;
  logic [11:0] pixel_color;
  logic [9:0]  curr_pix_x;
  logic [9:0]  curr_pix_y;
  logic        video_on;
  logic        pixel_tick;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic [3:0]  vga_red;
  logic [3:0]  vga_green;
  logic [3:0]  vga_blue;

  modport master (
    input  pixel_color,
    output curr_pix_x, curr_pix_y, video_on, pixel_tick, frame_start,
    output hsync, vsync, vga_red, vga_green, vga_blue
  );

  modport slave (
    output pixel_color,
    input  curr_pix_x, curr_pix_y, video_on, pixel_tick, frame_start,
    input  hsync, vsync, vga_red, vga_green, vga_blue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v position counters, registered
// active-low syncs, blanked RGB and a one-clock frame_start after each wrap.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic  clk,
  input  logic  rst,
  vga_if.master vga
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  logic [DW-1:0] div;
  logic [9:0]    pix_x;
  logic [9:0]    pix_y;
  logic          tick;
  logic          h_wrap;
  logic          v_wrap;
  logic          active;
  logic          hs_active;
  logic          vs_active;
  logic          hsync_q;
  logic          vsync_q;
  logic [3:0]    red_q;
  logic [3:0]    green_q;
  logic [3:0]    blue_q;
  logic          frame_start_q;

  // tick is gated by rst so a reset arriving on a tick cycle suppresses it
  always_comb begin
    tick      = !rst && (div == DIV_LAST);
    h_wrap    = (pix_x == H_LAST);
    v_wrap    = (pix_y == V_LAST);
    active    = (pix_x < H_VIS) && (pix_y < V_VIS);
    hs_active = (pix_x >= H_SYNC_BEG) && (pix_x <= H_SYNC_END);
    vs_active = (pix_y >= V_SYNC_BEG) && (pix_y <= V_SYNC_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div           <= '0;
      pix_x         <= '0;
      pix_y         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      red_q         <= 4'h0;
      green_q       <= 4'h0;
      blue_q        <= 4'h0;
      frame_start_q <= 1'b0;
    end else begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      if (tick) begin
        pix_x <= h_wrap ? 10'd0 : pix_x + 10'd1;
        if (h_wrap)
          pix_y <= v_wrap ? 10'd0 : pix_y + 10'd1;
      end
      hsync_q       <= !hs_active;
      vsync_q       <= !vs_active;
      red_q         <= active ? vga.pixel_color[11:8] : 4'h0;
      green_q       <= active ? vga.pixel_color[7:4]  : 4'h0;
      blue_q        <= active ? vga.pixel_color[3:0]  : 4'h0;
      frame_start_q <= tick && h_wrap && v_wrap;
    end
  end

  assign vga.curr_pix_x  = pix_x;
  assign vga.curr_pix_y  = pix_y;
  assign vga.video_on    = active;
  assign vga.pixel_tick  = tick;
  assign vga.frame_start = frame_start_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.vga_red     = red_q;
  assign vga.vga_green   = green_q;
  assign vga.vga_blue    = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance for line-level timing
// and a shrunken instance (15x8 pixels) so whole frames fit in the run.
module tb_vga_timing_gen;

  typedef struct {
    int          k;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  localparam int S_X = 0, S_Y = 1, S_TICK = 2, S_HS = 3, S_VS = 4, S_R = 5,
                 S_G = 6, S_B = 7, S_VID = 8, S_FS = 9, S_HSRUN = 10,
                 S_VSRUN = 11, S_FSRISE = 12, S_FSCYC = 13, S_MAXX = 14,
                 S_MAXY = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  vga_if vf ();
  vga_if vsm ();

  vga_timing_gen u_full (
    .clk (clk),
    .rst (rst),
    .vga (vf)
  );

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk (clk),
    .rst (rst_s),
    .vga (vsm)
  );

  int checks = 0;
  int failures = 0;
  chk_t qf[$];
  chk_t qs[$];

  // clocks elapsed since reset was last sampled high, per instance
  int kf = 0;
  int ks = 0;
  always @(posedge clk) begin
    kf <= rst ? 0 : kf + 1;
    ks <= rst_s ? 0 : ks + 1;
  end

  int hs_run[2], last_hs_run[2], vs_run[2], last_vs_run[2];
  int fs_rise[2], fs_cyc[2], max_x, max_y;
  logic prev_fs[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      hs_run[i] = 0; last_hs_run[i] = 0; vs_run[i] = 0; last_vs_run[i] = 0;
      fs_rise[i] = 0; fs_cyc[i] = 0; prev_fs[i] = 1'b0;
    end
    max_x = 0;
    max_y = 0;
  end

  function automatic logic [31:0] obs(input int s, input int sel);
    logic [31:0] v;
    v = 'x;
    case (sel)
      S_X:      v = 32'(s ? vsm.curr_pix_x  : vf.curr_pix_x);
      S_Y:      v = 32'(s ? vsm.curr_pix_y  : vf.curr_pix_y);
      S_TICK:   v = 32'(s ? vsm.pixel_tick  : vf.pixel_tick);
      S_HS:     v = 32'(s ? vsm.hsync       : vf.hsync);
      S_VS:     v = 32'(s ? vsm.vsync       : vf.vsync);
      S_R:      v = 32'(s ? vsm.vga_red     : vf.vga_red);
      S_G:      v = 32'(s ? vsm.vga_green   : vf.vga_green);
      S_B:      v = 32'(s ? vsm.vga_blue    : vf.vga_blue);
      S_VID:    v = 32'(s ? vsm.video_on    : vf.video_on);
      S_FS:     v = 32'(s ? vsm.frame_start : vf.frame_start);
      S_HSRUN:  v = 32'(last_hs_run[s]);
      S_VSRUN:  v = 32'(last_vs_run[s]);
      S_FSRISE: v = 32'(fs_rise[s]);
      S_FSCYC:  v = 32'(fs_cyc[s]);
      S_MAXX:   v = 32'(max_x);
      S_MAXY:   v = 32'(max_y);
      default:  v = 'x;
    endcase
    return v;
  endfunction

  task automatic measure(input int s, input logic hs, input logic vs, input logic fs);
    if (hs === 1'b0) hs_run[s]++;
    else if (hs_run[s] != 0) begin last_hs_run[s] = hs_run[s]; hs_run[s] = 0; end
    if (vs === 1'b0) vs_run[s]++;
    else if (vs_run[s] != 0) begin last_vs_run[s] = vs_run[s]; vs_run[s] = 0; end
    if (fs === 1'b1) fs_cyc[s]++;
    if (fs === 1'b1 && prev_fs[s] !== 1'b1) fs_rise[s]++;
    prev_fs[s] = fs;
  endtask

  // monitor: sample away from the active edge, pop expectations due this clock
  always @(negedge clk) begin
    chk_t c;
    logic [31:0] got;
    measure(0, vf.hsync, vf.vsync, vf.frame_start);
    measure(1, vsm.hsync, vsm.vsync, vsm.frame_start);
    if (!rst_s) begin
      if (int'(vsm.curr_pix_x) > max_x) max_x = int'(vsm.curr_pix_x);
      if (int'(vsm.curr_pix_y) > max_y) max_y = int'(vsm.curr_pix_y);
    end
    while (qf.size() > 0 && qf[0].k == kf) begin
      c = qf.pop_front();
      got = obs(0, c.sel);
      checks++;
      if (got !== c.exp) begin
        failures++;
        $display("FAIL full.%s k=%0d got=%0h want=%0h", c.name, kf, got, c.exp);
      end
    end
    while (qs.size() > 0 && qs[0].k == ks) begin
      c = qs.pop_front();
      got = obs(1, c.sel);
      checks++;
      if (got !== c.exp) begin
        failures++;
        $display("FAIL small.%s k=%0d got=%0h want=%0h", c.name, ks, got, c.exp);
      end
    end
  end

  task automatic pf(input int k, input int sel, input logic [31:0] e, input string n);
    chk_t c;
    c.k = k; c.sel = sel; c.exp = e; c.name = n;
    qf.push_back(c);
  endtask

  task automatic ps(input int k, input int sel, input logic [31:0] e, input string n);
    chk_t c;
    c.k = k; c.sel = sel; c.exp = e; c.name = n;
    qs.push_back(c);
  endtask

  task automatic wait_kf(input int n);
    int g = 0;
    while (kf != n && g < 20000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (kf != n) begin
      checks++;
      failures++;
      $display("FAIL wait_kf got=%0d want=%0d", kf, n);
    end
  endtask

  initial begin
    vf.pixel_color  = 12'hF00;
    vsm.pixel_color = 12'hF00;

    // full-size instance: reset state, divider, line timing, color path
    pf(0, S_X, 0, "rst_x");        pf(0, S_Y, 0, "rst_y");
    pf(0, S_TICK, 0, "rst_tick");  pf(0, S_HS, 1, "rst_hsync");
    pf(0, S_VS, 1, "rst_vsync");   pf(0, S_R, 0, "rst_red");
    pf(0, S_G, 0, "rst_green");    pf(0, S_B, 0, "rst_blue");
    pf(0, S_FS, 0, "rst_fs");      pf(0, S_VID, 1, "rst_video_on");
    pf(1, S_TICK, 0, "tick_k1");   pf(2, S_TICK, 0, "tick_k2");
    pf(3, S_TICK, 1, "tick_k3");   pf(3, S_X, 0, "x_k3");
    pf(4, S_X, 1, "x_k4");         pf(4, S_TICK, 0, "tick_k4");
    pf(7, S_TICK, 1, "tick_k7");
    pf(10, S_R, 4'hF, "red_vis");  pf(10, S_G, 0, "green_vis");
    pf(2559, S_VID, 1, "vid_x639");
    pf(2560, S_VID, 0, "vid_x640"); pf(2560, S_R, 4'hF, "red_lag_x640");
    pf(2561, S_R, 0, "red_blank");
    pf(2624, S_X, 656, "x_656");   pf(2624, S_HS, 1, "hs_before");
    pf(2625, S_HS, 0, "hs_first"); pf(3008, S_HS, 0, "hs_last");
    pf(3009, S_HS, 1, "hs_after"); pf(3010, S_HSRUN, 384, "hs_low_len");
    pf(3199, S_X, 799, "x_799");   pf(3199, S_Y, 0, "y_line0");
    pf(3199, S_VID, 0, "vid_x799");
    pf(3200, S_X, 0, "x_wrap");    pf(3200, S_Y, 1, "y_step");
    pf(3200, S_VID, 1, "vid_line1");
    pf(3300, S_R, 4'hF, "red_pre_step");
    pf(3301, S_G, 4'hF, "green_step"); pf(3301, S_R, 0, "red_step");
    pf(3302, S_G, 4'hF, "green_hold");
    pf(3303, S_B, 4'hF, "blue_step");  pf(3303, S_G, 0, "green_off");
    pf(3303, S_HS, 1, "hs_color_step"); pf(3303, S_VS, 1, "vs_color_step");
    pf(4403, S_X, 300, "x_300");   pf(4403, S_Y, 1, "y_pre_rst");
    pf(4403, S_B, 4'hF, "blue_pre_rst"); pf(4403, S_TICK, 0, "tick_in_rst");

    // small instance: 15x8 raster, whole frames
    ps(0, S_X, 0, "rst_x");        ps(0, S_Y, 0, "rst_y");
    ps(0, S_HS, 1, "rst_hsync");   ps(0, S_VS, 1, "rst_vsync");
    ps(32, S_R, 4'hF, "red_x7");   ps(33, S_R, 0, "red_x8");
    ps(40, S_X, 10, "x_10");       ps(40, S_HS, 1, "hs_before");
    ps(41, S_HS, 0, "hs_first");   ps(52, S_HS, 0, "hs_last");
    ps(53, S_HS, 1, "hs_after");   ps(54, S_HSRUN, 12, "hs_low_len");
    ps(240, S_Y, 4, "y_4");        ps(240, S_VID, 0, "vid_y4");
    ps(241, S_R, 0, "red_y4");
    ps(300, S_Y, 5, "y_5");        ps(300, S_VS, 1, "vs_before");
    ps(301, S_VS, 0, "vs_first");  ps(420, S_VS, 0, "vs_last");
    ps(421, S_VS, 1, "vs_after");  ps(425, S_VSRUN, 120, "vs_low_len");
    ps(479, S_X, 14, "x_last");    ps(479, S_Y, 7, "y_last");
    ps(479, S_FS, 0, "fs_pre_wrap"); ps(479, S_FSRISE, 0, "fs_none_frame0");
    ps(480, S_X, 0, "x_fwrap");    ps(480, S_Y, 0, "y_fwrap");
    ps(480, S_FS, 1, "fs_pulse1"); ps(481, S_FS, 0, "fs_width1");
    ps(960, S_FS, 1, "fs_pulse2"); ps(961, S_FS, 0, "fs_width2");
    ps(1000, S_FSRISE, 2, "fs_count"); ps(1000, S_FSCYC, 2, "fs_cycles");
    ps(1000, S_MAXX, 14, "max_x"); ps(1000, S_MAXY, 7, "max_y");

    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    rst_s = 1'b0;

    wait_kf(3300);
    vf.pixel_color = 12'h0F0;
    wait_kf(3302);
    vf.pixel_color = 12'h00F;

    // one-clock reset mid-frame on a tick cycle at x=300
    wait_kf(4403);
    rst = 1'b1;
    pf(0, S_X, 0, "mid_rst_x");    pf(0, S_Y, 0, "mid_rst_y");
    pf(0, S_HS, 1, "mid_rst_hs");  pf(0, S_VS, 1, "mid_rst_vs");
    pf(0, S_R, 0, "mid_rst_red");  pf(0, S_G, 0, "mid_rst_green");
    pf(0, S_B, 0, "mid_rst_blue"); pf(0, S_FS, 0, "mid_rst_fs");
    pf(0, S_TICK, 0, "mid_rst_tick");
    pf(1, S_FS, 0, "mid_rst_fs_k1"); pf(2, S_TICK, 0, "mid_rst_tick_k2");
    pf(3, S_TICK, 1, "mid_rst_tick_k3"); pf(4, S_X, 1, "mid_rst_x_k4");
    pf(8, S_X, 2, "mid_rst_x_k8");
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_kf(12);

    while (qf.size() > 0) begin
      chk_t c;
      c = qf.pop_front();
      checks++;
      failures++;
      $display("FAIL full.%s never reached got=none want=k%0d", c.name, c.k);
    end
    while (qs.size() > 0) begin
      chk_t c;
      c = qs.pop_front();
      checks++;
      failures++;
      $display("FAIL small.%s never reached got=none want=k%0d", c.name, c.k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
